// File: rtl/store_pack_pkg.sv
// Shared store-op encodings, buffer entry layout and the lane-packing helpers.
package store_pack_pkg;

  localparam int ST_OP_LENGTH = 2;
  localparam int ENTRY_W      = 68;

  typedef enum logic [ST_OP_LENGTH-1:0] {
    ST_SB  = 2'b00,
    ST_SH  = 2'b01,
    ST_SW  = 2'b10,
    ST_ILL = 2'b11
  } st_op_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } entry_t;

  // True when the request must be dropped: illegal op or misaligned address.
  function automatic logic store_bad(input logic [ST_OP_LENGTH-1:0] op, input logic [1:0] a);
    logic bad;
    bad = 1'b0;
    case (op)
      ST_SB:   bad = 1'b0;
      ST_SH:   bad = a[0];
      ST_SW:   bad = (a != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Word-aligns the address, replicates data across lanes and builds byte enables.
  function automatic entry_t pack_store(input logic [ST_OP_LENGTH-1:0] op,
                                        input logic [31:0] addr,
                                        input logic [31:0] data);
    entry_t e;
    e.addr  = {addr[31:2], 2'b00};
    e.wdata = data;
    e.be    = 4'b1111;
    case (op)
      ST_SB: begin
        e.wdata = {4{data[7:0]}};
        e.be    = 4'b0001 << addr[1:0];
      end
      ST_SH: begin
        e.wdata = {2{data[15:0]}};
        e.be    = addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        e.wdata = data;
        e.be    = 4'b1111;
      end
    endcase
    return e;
  endfunction

endpackage

// File: rtl/store_fifo.sv
// Circular store buffer: storage, wrapping pointers and occupancy count.
module store_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 68
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  // Head is forced to zero when nothing is buffered so reset leaves clean outputs.
  assign dout  = empty ? '0 : mem[rd_ptr];

  // Entry storage; written only on enqueue, never cleared.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally since DEPTH is a power of two; count tracks occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/store_pack.sv
// MEM-stage store packer: validates alignment, lane-replicates data, buffers
// accepted stores and drains them to data memory over valid/ready.
module store_pack
  import store_pack_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    st_valid,
  output logic                    st_ready,
  input  logic [ST_OP_LENGTH-1:0] st_op,
  input  logic [31:0]             st_addr,
  input  logic [31:0]             st_data,
  output logic                    st_err,
  output logic                    mem_valid,
  input  logic                    mem_ready,
  output logic [31:0]             mem_addr,
  output logic [31:0]             mem_wdata,
  output logic [3:0]              mem_be,
  output logic                    empty
);
  logic   accept;
  logic   bad;
  logic   push;
  logic   pop;
  logic   full;
  entry_t in_entry;
  entry_t head;

  assign st_ready  = !full;
  assign accept    = st_valid && st_ready;
  assign bad       = store_bad(st_op, st_addr[1:0]);
  assign push      = accept && !bad;
  assign in_entry  = pack_store(st_op, st_addr, st_data);
  assign mem_valid = !empty;
  assign pop       = mem_valid && mem_ready;
  assign mem_addr  = head.addr;
  assign mem_wdata = head.wdata;
  assign mem_be    = head.be;

  store_fifo #(
    .DEPTH(DEPTH),
    .W    (ENTRY_W)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .din  (in_entry),
    .pop  (pop),
    .dout (head),
    .full (full),
    .empty(empty)
  );

  // One-cycle error pulse for an accepted request that was dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st_err <= 1'b0;
    else        st_err <= accept && bad;
  end

endmodule

// File: tb/tb_store_pack.sv
// Bench for store_pack: vector table plus hand-written multi-cycle sequences,
// with a queue scoreboard checking every memory-side handshake in order.
module tb_store_pack;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st_valid;
  logic        st_ready;
  logic [1:0]  st_op;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_err;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        empty;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } exp_t;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_be;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[11];

  store_pack #(.DEPTH(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .st_valid (st_valid),
    .st_ready (st_ready),
    .st_op    (st_op),
    .st_addr  (st_addr),
    .st_data  (st_data),
    .st_err   (st_err),
    .mem_valid(mem_valid),
    .mem_ready(mem_ready),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_be   (mem_be),
    .empty    (empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    exp_t e;
    e.addr = a; e.wdata = d; e.be = b;
    exp_q.push_back(e);
  endtask

  // Scoreboard: every handshake must match the oldest expected store.
  always @(negedge clk) begin
    if (rst_n && mem_valid && mem_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL sb_unexpected: got addr %h with no store expected", mem_addr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_addr", mem_addr, e.addr);
        check("sb_wdata", mem_wdata, e.wdata);
        check("sb_be", {28'd0, mem_be}, {28'd0, e.be});
      end
    end
  end

  task automatic drain(input string name);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || mem_valid) && k < 20) begin
      @(negedge clk);
      k++;
    end
    check(name, {31'd0, mem_valid}, 32'd0);
    check({name, "_q"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit hit, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{2'b00, 32'h1000, 32'h0000_00AB, 1'b0, 32'h1000, 32'hABABABAB, 4'b0001};
    vecs[1]  = '{2'b00, 32'h1001, 32'h0000_00AB, 1'b0, 32'h1000, 32'hABABABAB, 4'b0010};
    vecs[2]  = '{2'b00, 32'h1002, 32'h0000_00AB, 1'b0, 32'h1000, 32'hABABABAB, 4'b0100};
    vecs[3]  = '{2'b00, 32'h1003, 32'h0000_00AB, 1'b0, 32'h1000, 32'hABABABAB, 4'b1000};
    vecs[4]  = '{2'b01, 32'h2002, 32'h0000_1234, 1'b0, 32'h2000, 32'h12341234, 4'b1100};
    vecs[5]  = '{2'b10, 32'h2004, 32'hDEADBEEF, 1'b0, 32'h2004, 32'hDEADBEEF, 4'b1111};
    vecs[6]  = '{2'b01, 32'h3001, 32'h0000_5555, 1'b1, 32'h0, 32'h0, 4'b0000};
    vecs[7]  = '{2'b10, 32'h3002, 32'h0000_5555, 1'b1, 32'h0, 32'h0, 4'b0000};
    vecs[8]  = '{2'b11, 32'h3000, 32'h0000_5555, 1'b1, 32'h0, 32'h0, 4'b0000};
    vecs[9]  = '{2'b01, 32'h2000, 32'hFFFF_5678, 1'b0, 32'h2000, 32'h56785678, 4'b0011};
    vecs[10] = '{2'b00, 32'h4003, 32'h1234_5699, 1'b0, 32'h4000, 32'h99999999, 4'b1000};

    rst_n = 1'b0; st_valid = 1'b0; st_op = 2'b00; st_addr = '0; st_data = '0; mem_ready = 1'b0;
    #12;
    check("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_st_ready", {31'd0, st_ready}, 32'd1);
    check("rst_st_err", {31'd0, st_err}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_be", {28'd0, mem_be}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table: one request at a time with memory always ready.
    mem_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1;
      st_valid = 1'b1; st_op = vecs[i].op; st_addr = vecs[i].addr; st_data = vecs[i].data;
      if (!vecs[i].err) push_exp(vecs[i].e_addr, vecs[i].e_wdata, vecs[i].e_be);
      @(posedge clk); #1;
      st_valid = 1'b0;
      @(negedge clk);
      check($sformatf("v%0d_st_err", i), {31'd0, st_err}, {31'd0, vecs[i].err});
      check($sformatf("v%0d_mem_valid", i), {31'd0, mem_valid}, {31'd0, !vecs[i].err});
      check($sformatf("v%0d_empty", i), {31'd0, empty}, {31'd0, vecs[i].err});
      @(negedge clk);
      check($sformatf("v%0d_err_clear", i), {31'd0, st_err}, 32'd0);
      check($sformatf("v%0d_drained", i), {31'd0, mem_valid}, 32'd0);
    end
    drain("table_drain");

    // Backpressure: three back-to-back SW with memory stalled.
    @(posedge clk); #1;
    mem_ready = 1'b0;
    st_valid = 1'b1; st_op = 2'b10; st_addr = 32'h5000; st_data = 32'hA0A0A0A0;
    push_exp(32'h5000, 32'hA0A0A0A0, 4'b1111);
    @(posedge clk); #1;
    check("bp_ready_after1", {31'd0, st_ready}, 32'd1);
    st_addr = 32'h5004; st_data = 32'hB1B1B1B1;
    push_exp(32'h5004, 32'hB1B1B1B1, 4'b1111);
    @(posedge clk); #1;
    check("bp_ready_after2", {31'd0, st_ready}, 32'd0);
    st_addr = 32'h5008; st_data = 32'hC2C2C2C2;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp_hold_addr", mem_addr, 32'h5000);
      check("bp_hold_wdata", mem_wdata, 32'hA0A0A0A0);
      check("bp_hold_ready", {31'd0, st_ready}, 32'd0);
    end
    @(posedge clk); #1;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_ready_back", {31'd0, st_ready}, 32'd1);
    push_exp(32'h5008, 32'hC2C2C2C2, 4'b1111);
    @(posedge clk); #1;
    st_valid = 1'b0;
    drain("bp_drain");

    // Simultaneous enqueue/dequeue at occupancy one for eight cycles.
    @(posedge clk); #1;
    mem_ready = 1'b0;
    st_valid = 1'b1; st_op = 2'b10; st_addr = 32'h6000; st_data = 32'h6000_0000;
    push_exp(32'h6000, 32'h6000_0000, 4'b1111);
    @(posedge clk); #1;
    mem_ready = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      st_addr = 32'h6000 + 32'(j * 4); st_data = 32'h6000_0000 + 32'(j);
      push_exp(32'h6000 + 32'(j * 4), 32'h6000_0000 + 32'(j), 4'b1111);
      @(negedge clk);
      check("sim_count", 32'(dut.u_fifo.count), 32'd1);
      check("sim_ready", {31'd0, st_ready}, 32'd1);
      @(posedge clk); #1;
    end
    st_valid = 1'b0;
    drain("sim_drain");

    // Asynchronous reset with two entries queued.
    @(posedge clk); #1;
    mem_ready = 1'b0;
    st_valid = 1'b1; st_op = 2'b10; st_addr = 32'h7000; st_data = 32'h77777777;
    @(posedge clk); #1;
    st_addr = 32'h7004;
    @(posedge clk); #1;
    st_valid = 1'b0;
    check("pre_rst_valid", {31'd0, mem_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", {31'd0, mem_valid}, 32'd0);
    check("async_rst_empty", {31'd0, empty}, 32'd1);
    check("async_rst_ready", {31'd0, st_ready}, 32'd1);
    check("async_rst_addr", mem_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b1;
    st_valid = 1'b1; st_op = 2'b01; st_addr = 32'h8002; st_data = 32'h0000_BEEF;
    push_exp(32'h8000, 32'hBEEFBEEF, 4'b1100);
    @(posedge clk); #1;
    st_valid = 1'b0;
    @(negedge clk);
    check("post_rst_valid", {31'd0, mem_valid}, 32'd1);
    drain("post_rst_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
